// File: rtl/segm7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : segm7_pkg                                                       |
// | Brief    : State encodings, hex-to-segment font and COM chain width helper |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package segm7_pkg;

    localparam int c_ST_W = 3;

    localparam logic [c_ST_W-1:0] c_ST_IDLE      = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_LOAD      = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_SHIFT     = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_LATCH     = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_HOLD      = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_FRAME_END = 3'd5;

    // COM chain is whole 74HC595 devices, so round the digit count up to 8.
    function automatic int com_bits(input int num_digits);
        return 8 * ((num_digits + 7) / 8);
    endfunction

    // Segment order a..g in bits 6..0.
    function automatic logic [6:0] seg7_font(input logic [3:0] nib);
        logic [6:0] f;
        case (nib)
            4'h0: f = 7'h7E;
            4'h1: f = 7'h30;
            4'h2: f = 7'h6D;
            4'h3: f = 7'h79;
            4'h4: f = 7'h33;
            4'h5: f = 7'h5B;
            4'h6: f = 7'h5F;
            4'h7: f = 7'h72;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h7B;
            4'hA: f = 7'h77;
            4'hB: f = 7'h1F;
            4'hC: f = 7'h4E;
            4'hD: f = 7'h3D;
            4'hE: f = 7'h4F;
            default: f = 7'h47;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/segm7_shift_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : segm7_shift_tx                                                  |
// | Brief    : Serialises one COM/SEG word pair into two 595 chains and       |
// |            latches both chains together                                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module segm7_shift_tx #(
    parameter int COM_BITS = 8,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [COM_BITS-1:0] i_com_word,
    input  logic [7:0]          i_seg_word,
    output logic                o_shift_end,
    output logic                o_latch_end,
    output logic                o_com_ser,
    output logic                o_com_srclk,
    output logic                o_com_rclk,
    output logic                o_seg_ser,
    output logic                o_seg_srclk,
    output logic                o_seg_rclk
);

    localparam int c_DIV_W = $clog2(CLK_DIV + 1);
    localparam int c_K_W   = $clog2(COM_BITS + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_K_W-1:0]   c_K_LAST   = c_K_W'(COM_BITS - 1);
    localparam logic [c_K_W-1:0]   c_K_SEG    = c_K_W'(COM_BITS - 8);
    localparam logic               c_SEG_FROM_START = (COM_BITS == 8);

    logic                r_shifting, r_latching, r_high, r_seg_en;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_K_W-1:0]    r_k;
    logic [COM_BITS-1:0] r_com_sr, r_seg_sr;
    logic                r_com_ser, r_com_srclk, r_seg_ser, r_seg_srclk, r_rclk;

    logic [COM_BITS-1:0] w_seg_ext;
    logic                w_div_last;

    // SEG rides on the last 8 bit slots of the COM shift, so align it to the top.
    assign w_seg_ext   = COM_BITS'(i_seg_word) << (COM_BITS - 8);
    assign w_div_last  = (r_div == c_DIV_LAST);
    assign o_shift_end = r_shifting & r_high & w_div_last & (r_k == c_K_LAST);
    assign o_latch_end = r_latching & w_div_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shifting  <= 1'b0;
            r_latching  <= 1'b0;
            r_high      <= 1'b0;
            r_seg_en    <= 1'b0;
            r_div       <= '0;
            r_k         <= '0;
            r_com_sr    <= '0;
            r_seg_sr    <= '0;
            r_com_ser   <= 1'b0;
            r_com_srclk <= 1'b0;
            r_seg_ser   <= 1'b0;
            r_seg_srclk <= 1'b0;
            r_rclk      <= 1'b0;
        end else if (i_start) begin
            r_shifting  <= 1'b1;
            r_latching  <= 1'b0;
            r_high      <= 1'b0;
            r_seg_en    <= c_SEG_FROM_START;
            r_div       <= '0;
            r_k         <= '0;
            r_com_sr    <= i_com_word >> 1;
            r_seg_sr    <= w_seg_ext >> 1;
            r_com_ser   <= i_com_word[0];
            r_seg_ser   <= w_seg_ext[0];
            r_com_srclk <= 1'b0;
            r_seg_srclk <= 1'b0;
            r_rclk      <= 1'b0;
        end else if (r_shifting) begin
            if (!w_div_last) begin
                r_div <= r_div + 1'b1;
            end else begin
                r_div <= '0;
                if (!r_high) begin
                    r_high      <= 1'b1;
                    r_com_srclk <= 1'b1;
                    r_seg_srclk <= r_seg_en;
                end else begin
                    r_high      <= 1'b0;
                    r_com_srclk <= 1'b0;
                    r_seg_srclk <= 1'b0;
                    if (r_k == c_K_LAST) begin
                        // Both chains latch on the same edge so no ghost digit appears.
                        r_shifting <= 1'b0;
                        r_latching <= 1'b1;
                        r_rclk     <= 1'b1;
                        r_com_ser  <= 1'b0;
                        r_seg_ser  <= 1'b0;
                    end else begin
                        r_k       <= r_k + 1'b1;
                        r_com_ser <= r_com_sr[0];
                        r_seg_ser <= r_seg_sr[0];
                        r_com_sr  <= r_com_sr >> 1;
                        r_seg_sr  <= r_seg_sr >> 1;
                        if (r_k + 1'b1 == c_K_SEG) begin
                            r_seg_en <= 1'b1;
                        end
                    end
                end
            end
        end else if (r_latching) begin
            if (!w_div_last) begin
                r_div <= r_div + 1'b1;
            end else begin
                r_div      <= '0;
                r_latching <= 1'b0;
                r_rclk     <= 1'b0;
            end
        end
    end

    assign o_com_ser   = r_com_ser;
    assign o_com_srclk = r_com_srclk;
    assign o_com_rclk  = r_rclk;
    assign o_seg_ser   = r_seg_ser;
    assign o_seg_srclk = r_seg_srclk;
    assign o_seg_rclk  = r_rclk;

endmodule
`default_nettype wire

// File: rtl/segm7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : segm7_scan_driver                                               |
// | Brief    : Multiplexed 7-segment scanner over COM/SEG 74HC595 chains with  |
// |            frame-synchronous shadow registers and clean blank-out on stop |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module segm7_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 4,
    parameter int HOLD_CYCLES    = 1024,
    parameter int COM_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARSTN,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    enable,
    input  logic                    load,
    output logic                    COM_SER,
    output logic                    COM_SRCLK,
    output logic                    COM_RCLK,
    output logic                    SEG_SER,
    output logic                    SEG_SRCLK,
    output logic                    SEG_RCLK,
    output logic                    frame_done,
    output logic                    busy
);
    import segm7_pkg::*;

    localparam int c_COM_BITS = com_bits(NUM_DIGITS);
    localparam int c_D_W      = $clog2(NUM_DIGITS + 1);
    localparam int c_H_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_D_W-1:0]      c_D_LAST   = c_D_W'(NUM_DIGITS - 1);
    localparam logic [c_H_W-1:0]      c_H_LAST   = c_H_W'(HOLD_CYCLES - 1);
    localparam logic [c_COM_BITS-1:0] c_COM_IDLE = (COM_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            c_SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [c_ST_W-1:0]       r_state;
    logic [c_D_W-1:0]        r_d;
    logic [c_H_W-1:0]        r_hold;
    logic                    r_pending, r_blanking, r_frame_done, r_busy;
    logic [4*NUM_DIGITS-1:0] r_sh_data;
    logic [NUM_DIGITS-1:0]   r_sh_dp, r_sh_blank;

    logic                    w_copy, w_is_load, w_hold_last, w_start;
    logic                    w_shift_end, w_latch_end, w_dp_bit, w_blank_bit;
    logic [4*NUM_DIGITS-1:0] w_data;
    logic [NUM_DIGITS-1:0]   w_dp, w_blank, w_digit_oh;
    logic [3:0]              w_nib;
    logic [7:0]              w_seg_raw, w_seg_word;
    logic [c_COM_BITS-1:0]   w_com_oh, w_com_word;

    // On the copy cycle digit 0 is built straight from the inputs so the whole
    // new frame, digit 0 included, shows the freshly loaded values.
    assign w_copy      = (r_state == c_ST_LOAD) && (r_d == '0) && r_pending;
    assign w_data      = w_copy ? digit_data : r_sh_data;
    assign w_dp        = w_copy ? dp_mask    : r_sh_dp;
    assign w_blank     = w_copy ? blank_mask : r_sh_blank;
    assign w_digit_oh  = NUM_DIGITS'(1) << r_d;
    assign w_nib       = 4'(w_data >> {r_d, 2'b00});
    assign w_dp_bit    = |(w_dp & w_digit_oh);
    assign w_blank_bit = |(w_blank & w_digit_oh);
    assign w_seg_raw   = w_blank_bit ? 8'h00 : {w_dp_bit, seg7_font(w_nib)};
    assign w_com_oh    = c_COM_BITS'(w_digit_oh);
    assign w_is_load   = (r_state == c_ST_LOAD);
    assign w_seg_word  = !w_is_load ? c_SEG_OFF
                       : ((SEG_ACTIVE_LOW != 0) ? ~w_seg_raw : w_seg_raw);
    assign w_com_word  = !w_is_load ? c_COM_IDLE
                       : ((COM_ACTIVE_LOW != 0) ? ~w_com_oh : w_com_oh);
    assign w_hold_last = (r_hold == c_H_LAST);
    assign w_start     = w_is_load || ((r_state == c_ST_HOLD) && w_hold_last && !enable);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) begin
            r_state      <= c_ST_IDLE;
            r_d          <= '0;
            r_hold       <= '0;
            r_pending    <= 1'b0;
            r_blanking   <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_sh_data    <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_copy) begin
                r_pending <= 1'b0;
            end
            if (w_copy) begin
                r_sh_data  <= digit_data;
                r_sh_dp    <= dp_mask;
                r_sh_blank <= blank_mask;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (enable) begin
                        r_state <= c_ST_LOAD;
                        r_d     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_LOAD: r_state <= c_ST_SHIFT;
                c_ST_SHIFT: begin
                    if (w_shift_end) begin
                        r_state <= c_ST_LATCH;
                    end
                end
                c_ST_LATCH: begin
                    if (w_latch_end) begin
                        if (r_blanking) begin
                            r_state    <= c_ST_IDLE;
                            r_blanking <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state <= c_ST_HOLD;
                            r_hold  <= '0;
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (!w_hold_last) begin
                        r_hold <= r_hold + 1'b1;
                    end else if (!enable) begin
                        // Blank-out pass: dark words shifted and latched once before idling.
                        r_blanking <= 1'b1;
                        r_state    <= c_ST_SHIFT;
                    end else if (r_d == c_D_LAST) begin
                        r_state      <= c_ST_FRAME_END;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_d     <= r_d + 1'b1;
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_FRAME_END: begin
                    r_d     <= '0;
                    r_state <= c_ST_LOAD;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    segm7_shift_tx #(
        .COM_BITS (c_COM_BITS),
        .CLK_DIV  (CLK_DIV)
    ) u_shift_tx (
        .clk         (S_AXI_ACLK),
        .rst_n       (S_AXI_ARSTN),
        .i_start     (w_start),
        .i_com_word  (w_com_word),
        .i_seg_word  (w_seg_word),
        .o_shift_end (w_shift_end),
        .o_latch_end (w_latch_end),
        .o_com_ser   (COM_SER),
        .o_com_srclk (COM_SRCLK),
        .o_com_rclk  (COM_RCLK),
        .o_seg_ser   (SEG_SER),
        .o_seg_srclk (SEG_SRCLK),
        .o_seg_rclk  (SEG_RCLK)
    );

    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_segm7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_segm7_scan_driver                                            |
// | Brief    : Directed bench with behavioural 74HC595 chain models           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_segm7_scan_driver;

    typedef struct packed {
        logic [15:0] com;
        logic [7:0]  seg;
        logic [7:0]  cp;
        logic [7:0]  sp;
    } lat_t;

    logic        clk, rst_n;
    logic [15:0] digit_data;
    logic [3:0]  dp_mask, blank_mask;
    logic        enable, load, en2;
    logic        com_ser, com_srclk, com_rclk, seg_ser, seg_srclk, seg_rclk, frame_done, busy;
    logic        com_ser2, com_srclk2, com_rclk2, seg_ser2, seg_srclk2, seg_rclk2, frame_done2, busy2;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    lat_t q1[$];
    lat_t q2[$];
    int   fd_q[$];

    segm7_scan_driver #(
        .NUM_DIGITS(4), .CLK_DIV(2), .HOLD_CYCLES(16), .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARSTN(rst_n), .digit_data(digit_data), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .enable(enable), .load(load),
        .COM_SER(com_ser), .COM_SRCLK(com_srclk), .COM_RCLK(com_rclk),
        .SEG_SER(seg_ser), .SEG_SRCLK(seg_srclk), .SEG_RCLK(seg_rclk),
        .frame_done(frame_done), .busy(busy)
    );

    segm7_scan_driver #(
        .NUM_DIGITS(12), .CLK_DIV(2), .HOLD_CYCLES(16), .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut12 (
        .S_AXI_ACLK(clk), .S_AXI_ARSTN(rst_n), .digit_data(48'd0), .dp_mask(12'd0),
        .blank_mask(12'd0), .enable(en2), .load(1'b0),
        .COM_SER(com_ser2), .COM_SRCLK(com_srclk2), .COM_RCLK(com_rclk2),
        .SEG_SER(seg_ser2), .SEG_SRCLK(seg_srclk2), .SEG_RCLK(seg_rclk2),
        .frame_done(frame_done2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 595 chain models: first bit shifted ends in bit 0 of the latched word.
    initial begin : mon1
        logic [7:0] sr_c, sr_s, lat_s;
        logic       p_cs, p_ss, p_cr, p_sr, p_fd;
        int         cp, sp;
        lat_t       rec;
        sr_c = '0; sr_s = '0; lat_s = '0; cp = 0; sp = 0;
        p_cs = 0; p_ss = 0; p_cr = 0; p_sr = 0; p_fd = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                cp = 0;
                sp = 0;
            end else begin
                if (com_srclk && !p_cs) begin sr_c = {com_ser, sr_c[7:1]}; cp++; end
                if (seg_srclk && !p_ss) begin sr_s = {seg_ser, sr_s[7:1]}; sp++; end
                if (seg_rclk && !p_sr) lat_s = sr_s;
                if (com_rclk && !p_cr) begin
                    rec = {8'h00, sr_c, lat_s, 8'(cp), 8'(sp)};
                    q1.push_back(rec);
                    cp = 0;
                    sp = 0;
                end
                if (frame_done && !p_fd) fd_q.push_back(cyc);
            end
            p_cs = com_srclk; p_ss = seg_srclk; p_cr = com_rclk; p_sr = seg_rclk; p_fd = frame_done;
        end
    end

    initial begin : mon2
        logic [15:0] sr_c;
        logic [7:0]  sr_s, lat_s;
        logic        p_cs, p_ss, p_cr, p_sr;
        int          cp, sp;
        lat_t        rec;
        sr_c = '0; sr_s = '0; lat_s = '0; cp = 0; sp = 0;
        p_cs = 0; p_ss = 0; p_cr = 0; p_sr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cp = 0;
                sp = 0;
            end else begin
                if (com_srclk2 && !p_cs) begin sr_c = {com_ser2, sr_c[15:1]}; cp++; end
                if (seg_srclk2 && !p_ss) begin sr_s = {seg_ser2, sr_s[7:1]}; sp++; end
                if (seg_rclk2 && !p_sr) lat_s = sr_s;
                if (com_rclk2 && !p_cr) begin
                    rec = {sr_c, lat_s, 8'(cp), 8'(sp)};
                    q2.push_back(rec);
                    cp = 0;
                    sp = 0;
                end
            end
            p_cs = com_srclk2; p_ss = seg_srclk2; p_cr = com_rclk2; p_sr = seg_rclk2;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic get_latch(input int which, output lat_t r);
        r = '0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (which == 1 && q1.size() > 0) begin r = q1.pop_front(); return; end
            if (which == 2 && q2.size() > 0) begin r = q2.pop_front(); return; end
        end
        check_eq($sformatf("latch_timeout_%0d", which), 0, 1);
    endtask

    task automatic check_digit(input int d, input logic [7:0] exp_seg);
        lat_t       r;
        logic [7:0] ec;
        get_latch(1, r);
        ec = ~(8'd1 << d);
        check_eq($sformatf("com_d%0d", d), r.com, {8'h00, ec});
        check_eq($sformatf("seg_d%0d", d), r.seg, exp_seg);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    function automatic logic [7:0] outs1();
        return {com_ser, com_srclk, com_rclk, seg_ser, seg_srclk, seg_rclk, frame_done, busy};
    endfunction

    initial begin : main
        lat_t r;
        int   n;
        rst_n = 1'b0; enable = 1'b0; en2 = 1'b0; load = 1'b0;
        digit_data = '0; dp_mask = '0; blank_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", outs1(), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_busy", busy, 0);
        enable = 1'b1;

        // Frame 1: shadow still zero; load during this frame lands in frame 2.
        check_digit(0, 8'h7E);
        digit_data = 16'h4321;
        pulse_load();
        for (int d = 1; d < 4; d++) check_digit(d, 8'h7E);

        // Frame 2
        check_digit(0, 8'h30);
        dp_mask = 4'b0101;
        blank_mask = 4'b0010;
        pulse_load();
        check_digit(1, 8'h6D);
        check_digit(2, 8'h79);
        check_digit(3, 8'h33);

        // Frame 3: data change without load must never show
        check_digit(0, 8'hB0);
        check_eq("frame_period", (fd_q.size() >= 2) ? 32'(fd_q[1] - fd_q[0]) : 32'd0, 205);
        digit_data = 16'hFFFF;
        check_digit(1, 8'h00);
        check_digit(2, 8'hF9);
        check_digit(3, 8'h33);

        // Frame 4: load mid-frame, current frame untouched
        check_digit(0, 8'hB0);
        pulse_load();
        check_digit(1, 8'h00);
        check_digit(2, 8'hF9);
        check_digit(3, 8'h33);

        // Frame 5: new data, then enable dropped during digit 2 shift
        check_digit(0, 8'hC7);
        check_digit(1, 8'h00);
        repeat (25) @(posedge clk);
        #1;
        enable = 1'b0;
        check_digit(2, 8'hC7);
        get_latch(1, r);
        check_eq("blank_com", r.com, 32'h00FF);
        check_eq("blank_seg", r.seg, 32'h00);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("busy_fall", busy, 0);
        @(negedge clk);
        check_eq("idle_outs", outs1(), 0);

        // Asynchronous reset in the middle of a shift
        enable = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("busy_run", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst_outs", outs1(), 0);
        repeat (3) @(posedge clk);
        #1;
        q1.delete();
        rst_n = 1'b1;
        get_latch(1, r);
        check_eq("rst_com_d0", r.com, 32'h00FE);
        check_eq("rst_seg_d0", r.seg, 32'h7E);
        check_eq("rst_com_pulses", r.cp, 8);
        check_eq("rst_seg_pulses", r.sp, 8);

        // 12-digit variant: 16-bit COM chain, inverted segments
        en2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            get_latch(2, r);
            if (i == 0) check_eq("d12_com_d0", r.com, 32'hFFFE);
            if (i == 9) begin
                check_eq("d12_com_d9", r.com, 32'hFDFF);
                check_eq("d12_seg_d9", r.seg, 32'h81);
                check_eq("d12_com_pulses", r.cp, 16);
                check_eq("d12_seg_pulses", r.sp, 8);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
